spi_sck_generator: RTL
======================

// Module: spi_sck_generator
// PURPOSE
//  Runtime-programmable SPI serial-clock engine for the nRF24L01 link. Generates SCK at
//  clk_50/(2*H) for any CPOL/CPHA mode, bursts a programmed number of SCK cycles per
//  start, and emits single-cycle sample/shift strobes aligned to SCK edges. Sits between
//  the SPI transaction FSM (start/done handshake) and the shift register / pin drivers.
// PARAMETERS
//  DIV_W    8   width of half-period input; H range 1..2^DIV_W-1
//  BITS_W   6   width of burst-length input; nbits range 0..2^BITS_W-1
// PORTS
//  clk_50      in   1       system clock, 50 MHz
//  rst         in   1       asynchronous, active-high reset
//  div_half    in   DIV_W   half-period H in clk_50 cycles; 0 treated as 1
//  cpol        in   1       SCK idle level
//  cpha        in   1       0: sample leading edge; 1: sample trailing edge
//  nbits       in   BITS_W  SCK cycles per burst
//  start       in   1       request burst; accepted only when busy=0
//  abort       in   1       terminate burst; priority over everything except rst
//  busy        out  1       burst in progress
//  done        out  1       1-cycle pulse: burst completed normally
//  sck         out  1       serial clock (registered)
//  sample_stb  out  1       1-cycle pulse coincident with each sampling edge
//  shift_stb   out  1       1-cycle pulse coincident with each launch edge
// BEHAVIOUR
//  - One clock, clk_50. rst is asynchronous and active-high. Reset: busy=0, done=0,
//    sck=0, sample_stb=0, shift_stb=0, FSM=IDLE, counters=0, latched cfg: cpol=0, H=1.
//  - IDLE: sck = latched cpol; cpol is re-latched from the input every idle cycle.
//  - Start accepted at cycle T (busy=0, abort=0): latch H (0->1), cpol, cpha, nbits.
//    nbits=0: done=1 at T+1, busy stays 0, no edges. Else busy=1 from T+1.
//  - FSM IDLE -> SETUP -> LEAD -> TRAIL ... -> TAIL -> IDLE; each phase lasts H cycles
//    (half-period timer reloads on terminal count).
//  - Edge i (i=1..2*nbits) visible on sck at cycle T+1+i*H; odd i = leading, even i =
//    trailing. Strobes are high in the same cycle the new sck level is visible.
//  - cpha=0: sample_stb on every leading edge; shift_stb on trailing edges except the last
//    (the first bit is presented by the consumer on start).
//  - cpha=1: shift_stb on every leading edge; sample_stb on every trailing edge.
//  - Exactly nbits sample_stb pulses per burst; sample_stb and shift_stb never both high.
//  - After edge 2*nbits sck is back at cpol; TAIL holds H cycles; done=1 and busy=0 at
//    T+1+(2*nbits+1)*H. busy duration = (2*nbits+1)*H cycles.
//  - start while busy=1: ignored. start in the cycle done=1: accepted (busy already 0).
//  - Input changes to div_half/cpol/cpha/nbits while busy: no effect until next start.
//  - abort (any state): next cycle busy=0, sck=latched cpol, strobes=0, no done pulse,
//    FSM=IDLE. abort and start same cycle: abort wins, start dropped.
//  - Counters are unsigned, DIV_W and BITS_W+1 bits wide; no wrap within a legal burst.
//  - rst mid-burst: all outputs to reset values immediately, no done.
// STRUCTURE
//  - spi_pkg: FSM state encoding (IDLE, SETUP, LEAD, TRAIL, TAIL), CPHA mode constants.
//  - Sub-module spi_halfperiod_timer: loadable down-counter, DIV_W wide, outputs
//    1-cycle terminal pulse; instantiated once. Edge/bit counting stays in this module.
// TESTING
//  - rst asserted mid-burst -> all outputs 0 within same cycle, no done after release.
//  - H=5, cpol=0, cpha=0, nbits=8, start at T -> busy T+1..T+85, first sck rise at T+6,
//    8 sample_stb on rises, 7 shift_stb on falls, done at T+86, sck ends 0.
//  - H=1, cpol=1, cpha=1, nbits=3 -> sck 1,0,1,0,1,0,1 toggling every cycle, 3 shift_stb
//    on falls, 3 sample_stb on rises, done at T+8.
//  - div_half=0, nbits=0 -> done at T+1, busy never high, sck constant.
//  - abort at 3rd edge with start also high -> busy=0 next cycle, sck=cpol, no done.
//  - start held high continuously, H=2, nbits=1 -> back-to-back bursts, each new start on
//    the done cycle; mid-burst changes to nbits/cpol ignored until next accept.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared constants for the SPI serial-clock engine.
//  - FSM state encoding for spi_sck_generator
//  - CPHA mode constants
package spi_pkg;

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StSetup = 3'd1;
    localparam logic [2:0] StLead  = 3'd2;  // last edge produced was a leading edge
    localparam logic [2:0] StTrail = 3'd3;  // last edge produced was a trailing edge
    localparam logic [2:0] StTail  = 3'd4;

    localparam logic CphaLead  = 1'b0;  // sample on leading edge
    localparam logic CphaTrail = 1'b1;  // sample on trailing edge

endpackage

// File: rtl/spi_halfperiod_timer.sv
// Loadable half-period down-counter.
// Ports:
//  clk_50    in  system clock
//  rst       in  asynchronous active-high reset
//  load      in  load load_val this cycle (takes priority over counting)
//  load_val  in  value loaded; a phase of H cycles is loaded as H-1
//  run       in  counting enabled
//  tc        out terminal-count pulse: run and count at zero
module spi_halfperiod_timer #(
    parameter int unsigned DIV_W = 8
) (
    input  logic             clk_50,
    input  logic             rst,
    input  logic             load,
    input  logic [DIV_W-1:0] load_val,
    input  logic             run,
    output logic             tc
);

    logic [DIV_W-1:0] cnt_q;

    always_ff @(posedge clk_50 or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (run && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign tc = run && (cnt_q == '0);

endmodule

// File: rtl/spi_sck_generator.sv
// Runtime-programmable SPI serial-clock engine.
// Produces SCK at clk_50/(2*H) for any CPOL/CPHA mode, bursts nbits SCK cycles per start,
// and emits single-cycle sample/shift strobes aligned with the visible SCK edges.
// Ports:
//  clk_50      in  system clock
//  rst         in  asynchronous active-high reset
//  div_half    in  half-period H in clk_50 cycles (0 treated as 1)
//  cpol        in  SCK idle level
//  cpha        in  0: sample leading edge, 1: sample trailing edge
//  nbits       in  SCK cycles per burst
//  start       in  burst request, accepted only when idle
//  abort       in  terminate burst, highest priority after rst
//  busy        out burst in progress
//  done        out 1-cycle pulse on normal completion
//  sck         out registered serial clock
//  sample_stb  out pulse with each sampling edge
//  shift_stb   out pulse with each launch edge
module spi_sck_generator
    import spi_pkg::*;
#(
    parameter int unsigned DIV_W  = 8,
    parameter int unsigned BITS_W = 6
) (
    input  logic              clk_50,
    input  logic              rst,
    input  logic [DIV_W-1:0]  div_half,
    input  logic              cpol,
    input  logic              cpha,
    input  logic [BITS_W-1:0] nbits,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              sck,
    output logic              sample_stb,
    output logic              shift_stb
);

    logic [2:0]        state_q, state_d;
    logic [DIV_W-1:0]  h_q, h_d;
    logic              cpol_q, cpol_d;
    logic              cpha_q, cpha_d;
    logic [BITS_W-1:0] nbits_q, nbits_d;
    logic [BITS_W:0]   edge_q, edge_d;
    logic              sck_q, sck_d;
    logic              done_q, done_d;
    logic              sample_q, sample_d;
    logic              shift_q, shift_d;

    logic              tmr_load;
    logic [DIV_W-1:0]  tmr_val;
    logic              tmr_tc;

    logic [DIV_W-1:0]  h_eff;
    logic [BITS_W:0]   edge_num;
    logic              last_edge;
    logic              leading;

    assign h_eff     = (div_half == '0) ? {{(DIV_W-1){1'b0}}, 1'b1} : div_half;
    assign edge_num  = edge_q + 1'b1;
    assign last_edge = (edge_num == {nbits_q, 1'b0});

    spi_halfperiod_timer #(
        .DIV_W (DIV_W)
    ) u_timer (
        .clk_50   (clk_50),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .run      (busy),
        .tc       (tmr_tc)
    );

    always_comb begin
        state_d  = state_q;
        h_d      = h_q;
        cpol_d   = cpol_q;
        cpha_d   = cpha_q;
        nbits_d  = nbits_q;
        edge_d   = edge_q;
        sck_d    = sck_q;
        done_d   = 1'b0;
        sample_d = 1'b0;
        shift_d  = 1'b0;
        tmr_load = 1'b0;
        tmr_val  = h_q - 1'b1;
        leading  = 1'b0;

        case (state_q)
            StIdle: begin
                // Idle line follows cpol; a start latches the rest of the configuration.
                cpol_d = cpol;
                sck_d  = cpol;
                if (start && !abort) begin
                    h_d     = h_eff;
                    cpha_d  = cpha;
                    nbits_d = nbits;
                    edge_d  = '0;
                    if (nbits == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d  = StSetup;
                        tmr_load = 1'b1;
                        tmr_val  = h_eff - 1'b1;
                    end
                end
            end
            default: begin
                if (abort) begin
                    state_d = StIdle;
                    sck_d   = cpol_q;
                end else if (tmr_tc) begin
                    tmr_load = 1'b1;
                    if (state_q == StTail) begin
                        state_d = StIdle;
                        done_d  = 1'b1;
                    end else begin
                        // From SETUP or after a trailing edge the next edge is leading.
                        leading = (state_q != StLead);
                        sck_d   = ~sck_q;
                        edge_d  = edge_num;
                        if (cpha_q == CphaLead) begin
                            sample_d = leading;
                            // First bit is already on the line, so no launch on the final edge.
                            shift_d  = !leading && !last_edge;
                        end else begin
                            sample_d = !leading;
                            shift_d  = leading;
                        end
                        if (leading) begin
                            state_d = StLead;
                        end else if (last_edge) begin
                            state_d = StTail;
                        end else begin
                            state_d = StTrail;
                        end
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk_50 or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            h_q      <= {{(DIV_W-1){1'b0}}, 1'b1};
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
            nbits_q  <= '0;
            edge_q   <= '0;
            sck_q    <= 1'b0;
            done_q   <= 1'b0;
            sample_q <= 1'b0;
            shift_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            h_q      <= h_d;
            cpol_q   <= cpol_d;
            cpha_q   <= cpha_d;
            nbits_q  <= nbits_d;
            edge_q   <= edge_d;
            sck_q    <= sck_d;
            done_q   <= done_d;
            sample_q <= sample_d;
            shift_q  <= shift_d;
        end
    end

    assign busy       = (state_q != StIdle);
    assign done       = done_q;
    assign sck        = sck_q;
    assign sample_stb = sample_q;
    assign shift_stb  = shift_q;

endmodule
